// File: rtl/i2c_reg_access.sv
// Register-access sequencer for top_i2c_master: turns one CPU request into the
// EN/RW/ADDR/DATA_WR drive sequence for an 8-bit register write or read.
module i2c_reg_access #(
  parameter int ADDR_SZ = 7,
  parameter int DATA_SZ = 8,
  parameter int TIMEOUT = 50_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I_REQ,
  input  logic               I_RW,
  input  logic [ADDR_SZ-1:0] I_DEV_ADDR,
  input  logic [DATA_SZ-1:0] I_REG_ADDR,
  input  logic [DATA_SZ-1:0] I_WDATA,
  output logic               O_READY,
  output logic               O_DONE,
  output logic [DATA_SZ-1:0] O_RDATA,
  output logic               O_ERR,
  output logic               O_TMO,
  output logic               O_M_EN,
  output logic               O_M_RW,
  output logic [ADDR_SZ-1:0] O_M_ADDR,
  output logic [DATA_SZ-1:0] O_M_DATA_WR,
  input  logic               I_M_BUSY,
  input  logic               I_M_ACK_FL,
  input  logic [DATA_SZ-1:0] I_M_DATA_RD
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BYTE1, S_BYTE2, S_WAIT_END, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d, rw_q, rw_d, op_rw_q, op_rw_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [DATA_SZ-1:0] data_wr_q, data_wr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic               done_q, done_d, err_q, err_d, tmo_q, tmo_d;
  logic               rise, fall, err_now, expired, waiting;

  assign rise    = I_M_BUSY & ~busy_q;
  assign fall    = ~I_M_BUSY & busy_q;
  assign err_now = err_q | I_M_ACK_FL;
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign waiting = (state_q == S_START) || (state_q == S_BYTE1) ||
                   (state_q == S_BYTE2) || (state_q == S_WAIT_END);

  assign O_READY     = (state_q == S_IDLE) & ~I_M_BUSY;
  assign O_DONE      = done_q;
  assign O_RDATA     = rdata_q;
  assign O_ERR       = err_q;
  assign O_TMO       = tmo_q;
  assign O_M_EN      = en_q;
  assign O_M_RW      = rw_q;
  assign O_M_ADDR    = addr_q;
  assign O_M_DATA_WR = data_wr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = waiting ? cnt_q + CNT_W'(1) : cnt_q;
    en_d      = en_q;
    rw_d      = rw_q;
    op_rw_d   = op_rw_q;
    addr_d    = addr_q;
    data_wr_d = data_wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = err_q;
    tmo_d     = tmo_q;
    if (state_q != S_IDLE && I_M_ACK_FL) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (I_REQ && O_READY) begin
          en_d      = 1'b1;
          rw_d      = 1'b0;
          addr_d    = I_DEV_ADDR;
          data_wr_d = I_REG_ADDR;
          wdata_d   = I_WDATA;
          op_rw_d   = I_RW;
          err_d     = 1'b0;
          tmo_d     = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (rise) begin
          if (op_rw_q) rw_d = 1'b1;
          else         data_wr_d = wdata_q;
          state_d = S_BYTE1;
        end else if (fall && err_now) begin
          en_d    = 1'b0;
          state_d = S_WAIT_END;
        end
      end
      S_BYTE1: begin
        // Falls between bytes are normal; only a NACKed transfer ends here.
        if (rise) begin
          en_d    = 1'b0;
          state_d = S_BYTE2;
        end else if (fall && err_now) begin
          en_d    = 1'b0;
          state_d = S_WAIT_END;
        end
      end
      S_BYTE2: begin
        if (fall) begin
          if (op_rw_q && !err_now) rdata_d = I_M_DATA_RD;
          state_d = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Timeout overrides whatever the waiting state decided this cycle.
    if (waiting && expired) begin
      en_d    = 1'b0;
      tmo_d   = 1'b1;
      done_d  = 1'b1;
      state_d = S_DONE;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      op_rw_q   <= 1'b0;
      addr_q    <= '0;
      data_wr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= I_M_BUSY;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      rw_q      <= rw_d;
      op_rw_q   <= op_rw_d;
      addr_q    <= addr_d;
      data_wr_q <= data_wr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_i2c_reg_access.sv
// Bench for i2c_reg_access: scripted master busy/ack behaviour, expected
// completions queued at request time and checked by a separate O_DONE monitor.
module tb_i2c_reg_access;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_rw;
  logic [AW-1:0] i_dev;
  logic [DW-1:0] i_reg, i_wdata;
  logic          o_ready, o_done, o_err, o_tmo;
  logic [DW-1:0] o_rdata;
  logic          m_en, m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_wr;
  logic          m_busy, m_ack_fl;
  logic [DW-1:0] m_data_rd;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW+1:0] exp_q[$];   // {rdata, err, tmo}
  logic [DW-1:0] rdata_m;    // reference copy of O_RDATA
  logic          prev_done = 1'b0;

  i2c_reg_access #(.ADDR_SZ(AW), .DATA_SZ(DW), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst),
    .I_REQ(i_req), .I_RW(i_rw), .I_DEV_ADDR(i_dev), .I_REG_ADDR(i_reg),
    .I_WDATA(i_wdata),
    .O_READY(o_ready), .O_DONE(o_done), .O_RDATA(o_rdata), .O_ERR(o_err),
    .O_TMO(o_tmo),
    .O_M_EN(m_en), .O_M_RW(m_rw), .O_M_ADDR(m_addr), .O_M_DATA_WR(m_data_wr),
    .I_M_BUSY(m_busy), .I_M_ACK_FL(m_ack_fl), .I_M_DATA_RD(m_data_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!o_ready && k < 300) begin
      tick();
      k++;
    end
    chk("ready_wait", {31'd0, o_ready}, 32'd1);
  endtask

  // Monitor: every O_DONE pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (prev_done) chk("done_one_cycle", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        chk("done_rdata", {24'd0, o_rdata}, {24'd0, e[DW+1:2]});
        chk("done_err", {31'd0, o_err}, {31'd0, e[1]});
        chk("done_tmo", {31'd0, o_tmo}, {31'd0, e[0]});
      end
    end
    prev_done = o_done;
  end

  task automatic accept(input logic rw, input logic [AW-1:0] dev,
                        input logic [DW-1:0] rg, input logic [DW-1:0] wd);
    wait_ready();
    i_req = 1'b1; i_rw = rw; i_dev = dev; i_reg = rg; i_wdata = wd;
    tick();
    i_req = 1'b0;
    chk("acc_en", {31'd0, m_en}, 32'd1);
    chk("acc_rw", {31'd0, m_rw}, 32'd0);
    chk("acc_addr", {25'd0, m_addr}, {25'd0, dev});
    chk("acc_data", {24'd0, m_data_wr}, {24'd0, rg});
    chk("acc_ready", {31'd0, o_ready}, 32'd0);
  endtask

  // Full operation against a scripted master; nack ends after the first byte.
  task automatic do_op(input logic rw, input logic [AW-1:0] dev,
                       input logic [DW-1:0] rg, input logic [DW-1:0] wd,
                       input logic [DW-1:0] sd, input logic nack, input logic poke);
    if (rw && !nack) rdata_m = sd;
    exp_q.push_back({rdata_m, nack, 1'b0});
    accept(rw, dev, rg, wd);
    ticks(3);
    m_busy = 1'b1;
    ticks(5);
    chk("b1_en", {31'd0, m_en}, 32'd1);
    chk("b1_rw", {31'd0, m_rw}, {31'd0, rw});
    chk("b1_addr", {25'd0, m_addr}, {25'd0, dev});
    if (!rw) chk("b1_wdata", {24'd0, m_data_wr}, {24'd0, wd});
    if (poke) begin
      chk("busy_ready", {31'd0, o_ready}, 32'd0);
      i_req = 1'b1; i_rw = ~rw; i_dev = ~dev; i_reg = ~rg; i_wdata = ~wd;
      tick();
      i_req = 1'b0;
    end
    if (nack) begin
      m_ack_fl = 1'b1;
      tick();
      m_ack_fl = 1'b0;
      ticks(5);
      m_busy = 1'b0;
    end else begin
      ticks(12);
      m_busy = 1'b0;
      ticks(3);
      m_busy = 1'b1;
      ticks(5);
      chk("b2_en", {31'd0, m_en}, 32'd0);
      chk("b2_addr", {25'd0, m_addr}, {25'd0, dev});
      ticks(12);
      m_data_rd = sd;
      m_busy = 1'b0;
    end
    ticks(2);
    wait_ready();
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_rw = 1'b0; i_dev = '0; i_reg = '0; i_wdata = '0;
    m_busy = 1'b0; m_ack_fl = 1'b0; m_data_rd = '0; rdata_m = '0;
    ticks(3);
    chk("rst_en", {31'd0, m_en}, 32'd0);
    chk("rst_addr", {25'd0, m_addr}, 32'd0);
    chk("rst_rdata", {24'd0, o_rdata}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    rst = 1'b0;
    tick();

    do_op(1'b0, 7'h77, 8'h0C, 8'hAA, 8'h3C, 1'b0, 1'b0);
    do_op(1'b1, 7'h55, 8'h10, 8'h00, 8'h88, 1'b0, 1'b0);
    do_op(1'b0, 7'h77, 8'h0C, 8'hAA, 8'h5A, 1'b1, 1'b0);
    do_op(1'b1, 7'h55, 8'h10, 8'h00, 8'hC3, 1'b1, 1'b0);
    do_op(1'b1, 7'h2A, 8'h44, 8'h00, 8'h96, 1'b0, 1'b1);

    // Timeout: master never goes busy; expiry lands 100 cycles after START.
    exp_q.push_back({rdata_m, 1'b0, 1'b1});
    accept(1'b0, 7'h77, 8'h01, 8'h02);
    ticks(TMO - 1);
    chk("tmo_early", {30'd0, o_tmo, o_done}, 32'd0);
    tick();
    chk("tmo_flag", {31'd0, o_tmo}, 32'd1);
    chk("tmo_done", {31'd0, o_done}, 32'd1);
    chk("tmo_en", {31'd0, m_en}, 32'd0);
    ticks(2);
    wait_ready();

    // Reset during BYTE1 with the master still busy.
    accept(1'b1, 7'h31, 8'h22, 8'h00);
    ticks(3);
    m_busy = 1'b1;
    ticks(5);
    #2 rst = 1'b1;
    #1;
    chk("mrst_en", {31'd0, m_en}, 32'd0);
    chk("mrst_rw", {31'd0, m_rw}, 32'd0);
    chk("mrst_data", {24'd0, m_data_wr}, 32'd0);
    chk("mrst_flags", {29'd0, o_done, o_err, o_tmo}, 32'd0);
    chk("mrst_rdata", {24'd0, o_rdata}, 32'd0);
    chk("mrst_ready", {31'd0, o_ready}, 32'd0);
    rdata_m = '0;
    ticks(2);
    rst = 1'b0;
    ticks(3);
    chk("mrst_ready_busy", {31'd0, o_ready}, 32'd0);
    m_busy = 1'b0;
    #1;
    chk("mrst_ready_idle", {31'd0, o_ready}, 32'd1);
    tick();

    for (int t = 0; t < 16; t++) begin
      do_op(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end

    ticks(5);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
